// File: rtl/spi_flash_line_buffer.sv
// Single-line, read-only prefetch buffer in front of the OBI SPI flash reader.
// A hit answers one cycle after grant; a miss refills the whole aligned line
// one downstream word at a time and then answers the requested word.
module spi_flash_line_buffer #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  s_req_i,
    output logic                  s_gnt_o,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic                  s_we_i,
    output logic                  s_rvalid_o,
    output logic [31:0]           s_rdata_o,
    output logic                  m_req_o,
    input  logic                  m_gnt_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    input  logic                  m_rvalid_i,
    input  logic [31:0]           m_rdata_i,
    output logic                  hit_o,
    output logic                  miss_o
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF   = IDX_W + 2;
    localparam int unsigned TAG_W = ADDR_WIDTH - OFF;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             valid_q;
    logic             flush_pending_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;
    logic [31:0]      line_q [LINE_WORDS];
    logic             rvalid_q;
    logic [31:0]      rdata_q;

    // Host address decode; the byte lane bits carry no information here.
    logic [TAG_W-1:0] s_tag;
    logic [IDX_W-1:0] s_idx;
    logic             unused_byte_bits;
    assign s_tag            = s_addr_i[ADDR_WIDTH-1:OFF];
    assign s_idx            = s_addr_i[OFF-1:2];
    assign unused_byte_bits = ^s_addr_i[1:0];

    logic accept, is_hit, rd_hit, rd_miss, last_word;
    assign accept    = (state_q == IDLE) && s_req_i;
    assign is_hit    = valid_q && (s_tag == tag_q);
    assign rd_hit    = accept && !s_we_i && is_hit;
    assign rd_miss   = accept && !s_we_i && !is_hit;
    assign last_word = (cnt_q == IDX_W'(LINE_WORDS - 1));

    // Next-state and per-state outputs of the fill sequencer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        s_gnt_o  = 1'b0;
        m_req_o  = 1'b0;
        m_addr_o = '0;
        hit_o    = 1'b0;
        miss_o   = 1'b0;
        case (state_q)
            IDLE: begin
                s_gnt_o = s_req_i;
                hit_o   = rd_hit;
                miss_o  = rd_miss;
                if (rd_miss) state_d = REQ;
            end
            REQ: begin
                m_req_o  = 1'b1;
                // The counter sits below the tag, so the word address never carries into it.
                m_addr_o = {tag_q, cnt_q, 2'b00};
                if (m_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (m_rvalid_i) state_d = last_word ? RESP : REQ;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus line bookkeeping (tag, valid, flush tracking, fill counter).
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst_i) begin
            state_q         <= IDLE;
            valid_q         <= 1'b0;
            flush_pending_q <= 1'b0;
            tag_q           <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
        end else begin
            state_q  <= state_d;
            // Hits and writes answer next cycle; writes answer with zero data.
            rvalid_q <= accept && !rd_miss;
            rdata_q  <= rd_hit ? line_q[s_idx] : '0;
            case (state_q)
                IDLE: begin
                    if (rd_miss) begin
                        tag_q           <= s_tag;
                        idx_q           <= s_idx;
                        cnt_q           <= '0;
                        valid_q         <= 1'b0;
                        flush_pending_q <= 1'b0;
                    end else if (flush_i) begin
                        valid_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_i) flush_pending_q <= 1'b1;
                end
                WAIT: begin
                    if (flush_i) flush_pending_q <= 1'b1;
                    if (m_rvalid_i && !last_word) cnt_q <= cnt_q + IDX_W'(1);
                end
                RESP: begin
                    // A flush seen at any point of the fill leaves the new line invalid.
                    valid_q         <= !(flush_pending_q || flush_i);
                    flush_pending_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Line data array, written one word per downstream response.
    always_ff @(posedge clk_i) begin
        // NOTE: the data array is not reset; valid_q guards every read of it.
        if (state_q == WAIT && m_rvalid_i) line_q[cnt_q] <= m_rdata_i;
    end

    assign s_rvalid_o = rvalid_q || (state_q == RESP);
    assign s_rdata_o  = (state_q == RESP) ? line_q[idx_q] : rdata_q;

`ifndef SYNTHESIS
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (m_req_o && !m_gnt_i) |=> $stable(m_addr_o));
    a_gnt_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        s_gnt_o |-> (state_q == IDLE));
`endif

endmodule

// File: tb/tb_spi_flash_line_buffer.sv
// Directed bench for spi_flash_line_buffer with a fixed-latency downstream model.
module tb_spi_flash_line_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        s_req_i = 1'b0;
    logic        s_gnt_o;
    logic [31:0] s_addr_i = '0;
    logic        s_we_i = 1'b0;
    logic        s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        m_req_o;
    logic        m_gnt_i;
    logic [31:0] m_addr_o;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic        hit_o;
    logic        miss_o;

    int checks = 0;
    int errors = 0;

    int hit_cnt, miss_cnt, rvalid_cnt, req_cycles;
    logic [31:0] addr_log[$];

    spi_flash_line_buffer #(.LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
        .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .hit_o(hit_o), .miss_o(miss_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream: grant on the 2nd request cycle, respond 2 cycles after grant.
    initial begin
        int          phase;
        int          cnt;
        logic [31:0] lat_addr;
        phase = 0; cnt = 0; lat_addr = '0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        forever begin
            @(posedge clk_i); #2;
            m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
            if (rst_i) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (m_req_o) begin
                    cnt++;
                    if (cnt == 2) begin
                        m_gnt_i = 1'b1; lat_addr = m_addr_o; phase = 1; cnt = 0;
                    end
                end
            end else begin
                cnt++;
                if (cnt == 2) begin
                    m_rvalid_i = 1'b1; m_rdata_i = lat_addr ^ 32'hA5A5_0000; phase = 0; cnt = 0;
                end
            end
        end
    end

    // Event monitor sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (hit_o) hit_cnt++;
            if (miss_o) miss_cnt++;
            if (s_rvalid_o) rvalid_cnt++;
            if (m_req_o) req_cycles++;
            if (m_req_o && m_gnt_i) addr_log.push_back(m_addr_o);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        hit_cnt = 0; miss_cnt = 0; rvalid_cnt = 0; req_cycles = 0;
        addr_log.delete();
    endtask

    // One host transaction; lat = cycles from grant to rvalid, -1 on timeout.
    task automatic do_txn(input logic [31:0] addr, input logic we,
                          output logic [31:0] rdata, output int lat, output logic gnt);
        @(posedge clk_i); #1;
        s_req_i = 1'b1; s_addr_i = addr; s_we_i = we;
        @(negedge clk_i);
        gnt = s_gnt_o;
        @(posedge clk_i); #1;
        s_req_i = 1'b0; s_we_i = 1'b0;
        lat = -1; rdata = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_i);
            if (s_rvalid_o) begin
                lat = i; rdata = s_rdata_o;
                break;
            end
        end
        #2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({s_gnt_o, s_rvalid_o, m_req_o, hit_o, miss_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {s_gnt_o, s_rvalid_o, m_req_o, hit_o, miss_o});
        end
        checks++;
        if (s_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", s_rdata_o); end
        checks++;
        if (m_addr_o !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h exp 0", m_addr_o); end
    endtask

    task automatic test_cold_miss();
        logic [31:0] rd; int lat; logic g;
        logic [31:0] exp_a [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        clear_counts();
        do_txn(32'h0000_0108, 1'b0, rd, lat, g);
        checks++;
        if (g !== 1'b1) begin errors++; $display("FAIL cold_gnt got %b exp 1", g); end
        checks++;
        if (rd !== 32'hA5A5_0108) begin errors++; $display("FAIL cold_rdata got %h exp a5a50108", rd); end
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL cold_latency got %0d exp 17", lat); end
        checks++;
        if (miss_cnt !== 1 || hit_cnt !== 0 || rvalid_cnt !== 1) begin
            errors++; $display("FAIL cold_pulses got miss %0d hit %0d rvalid %0d exp 1 0 1", miss_cnt, hit_cnt, rvalid_cnt);
        end
        checks++;
        if (addr_log.size() !== 4) begin
            errors++; $display("FAIL cold_fetch_count got %0d exp 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== exp_a[i]) begin
                    errors++; $display("FAIL cold_maddr%0d got %h exp %h", i, addr_log[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'h100, 32'h104, 32'h10C};
        clear_counts();
        for (int i = 0; i <= 3; i++) begin
            @(posedge clk_i); #1;
            if (i < 3) begin s_req_i = 1'b1; s_addr_i = a[i]; end
            else s_req_i = 1'b0;
            @(negedge clk_i);
            if (i < 3) begin
                checks++;
                if (s_gnt_o !== 1'b1 || hit_o !== 1'b1) begin
                    errors++; $display("FAIL b2b_gnt%0d got gnt %b hit %b exp 1 1", i, s_gnt_o, hit_o);
                end
            end
            checks++;
            if (s_rvalid_o !== (i > 0)) begin
                errors++; $display("FAIL b2b_rvalid%0d got %b exp %b", i, s_rvalid_o, i > 0);
            end
            if (i > 0) begin
                checks++;
                if (s_rdata_o !== (a[i-1] ^ 32'hA5A5_0000)) begin
                    errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, s_rdata_o, a[i-1] ^ 32'hA5A5_0000);
                end
            end
        end
        @(negedge clk_i); #2;
        checks++;
        if (s_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_tail got %b exp 0", s_rvalid_o); end
        checks++;
        if (hit_cnt !== 3 || miss_cnt !== 0 || req_cycles !== 0) begin
            errors++; $display("FAIL b2b_counts got hit %0d miss %0d req %0d exp 3 0 0", hit_cnt, miss_cnt, req_cycles);
        end
    endtask

    task automatic test_line_replace();
        logic [31:0] rd; int lat; logic g;
        clear_counts();
        do_txn(32'h110, 1'b0, rd, lat, g);
        checks++;
        if (rd !== 32'hA5A5_0110 || miss_cnt !== 1) begin
            errors++; $display("FAIL repl_first got %h miss %0d exp a5a50110 1", rd, miss_cnt);
        end
        checks++;
        if (addr_log.size() !== 4 || addr_log[0] !== 32'h110 || addr_log[3] !== 32'h11C) begin
            errors++; $display("FAIL repl_maddr got n=%0d first %h exp 4 110..11c", addr_log.size(),
                               addr_log.size() > 0 ? addr_log[0] : 32'hX);
        end
        clear_counts();
        do_txn(32'h100, 1'b0, rd, lat, g);
        checks++;
        if (miss_cnt !== 1 || lat !== 17 || rd !== 32'hA5A5_0100) begin
            errors++; $display("FAIL repl_evict got miss %0d lat %0d data %h exp 1 17 a5a50100", miss_cnt, lat, rd);
        end
    endtask

    task automatic test_flush_mid_fill();
        logic [31:0] rd; int lat; logic g; logic seen;
        clear_counts();
        seen = 1'b0;
        fork
            do_txn(32'h128, 1'b0, rd, lat, g);
            begin
                for (int i = 0; i < 60 && !seen; i++) begin
                    @(negedge clk_i); #2;
                    if (addr_log.size() >= 3) seen = 1'b1;
                end
                if (seen) begin
                    @(posedge clk_i); #1 flush_i = 1'b1;
                    @(posedge clk_i); #1 flush_i = 1'b0;
                end
            end
        join
        checks++;
        if (!seen) begin errors++; $display("FAIL flush_third_grant got none exp seen"); end
        checks++;
        if (rd !== 32'hA5A5_0128 || lat !== 17) begin
            errors++; $display("FAIL flush_fill_data got %h lat %0d exp a5a50128 17", rd, lat);
        end
        clear_counts();
        do_txn(32'h128, 1'b0, rd, lat, g);
        checks++;
        if (miss_cnt !== 1 || hit_cnt !== 0 || rd !== 32'hA5A5_0128) begin
            errors++; $display("FAIL flush_reread got miss %0d hit %0d data %h exp 1 0 a5a50128", miss_cnt, hit_cnt, rd);
        end
    endtask

    task automatic test_write();
        logic [31:0] rd; int lat; logic g;
        do_txn(32'h100, 1'b0, rd, lat, g);
        clear_counts();
        do_txn(32'h100, 1'b1, rd, lat, g);
        checks++;
        if (g !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
            errors++; $display("FAIL write_resp got gnt %b lat %0d data %h exp 1 1 0", g, lat, rd);
        end
        checks++;
        if (hit_cnt !== 0 || miss_cnt !== 0 || req_cycles !== 0) begin
            errors++; $display("FAIL write_pulses got hit %0d miss %0d req %0d exp 0 0 0", hit_cnt, miss_cnt, req_cycles);
        end
        do_txn(32'h100, 1'b0, rd, lat, g);
        checks++;
        if (hit_cnt !== 1 || lat !== 1 || rd !== 32'hA5A5_0100) begin
            errors++; $display("FAIL write_then_read got hit %0d lat %0d data %h exp 1 1 a5a50100", hit_cnt, lat, rd);
        end
    endtask

    task automatic test_flush_idle();
        logic [31:0] rd; int lat; logic g; logic h;
        clear_counts();
        @(posedge clk_i); #1;
        s_req_i = 1'b1; s_addr_i = 32'h104; flush_i = 1'b1;
        @(negedge clk_i);
        h = hit_o;
        @(posedge clk_i); #1;
        s_req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (h !== 1'b1 || s_rvalid_o !== 1'b1 || s_rdata_o !== 32'hA5A5_0104) begin
            errors++; $display("FAIL flush_idle_hit got hit %b rvalid %b data %h exp 1 1 a5a50104", h, s_rvalid_o, s_rdata_o);
        end
        #2;
        do_txn(32'h104, 1'b0, rd, lat, g);
        checks++;
        if (miss_cnt !== 1 || rd !== 32'hA5A5_0104) begin
            errors++; $display("FAIL flush_idle_reread got miss %0d data %h exp 1 a5a50104", miss_cnt, rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int lat; logic g; logic seen;
        clear_counts();
        seen = 1'b0;
        @(posedge clk_i); #1;
        s_req_i = 1'b1; s_addr_i = 32'h200;
        @(posedge clk_i); #1;
        s_req_i = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i); #2;
            if (addr_log.size() >= 1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_fill_grant got none exp seen"); end
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({s_gnt_o, s_rvalid_o, m_req_o, hit_o, miss_o} !== 5'b0 || m_addr_o !== 32'h0 || s_rdata_o !== 32'h0) begin
            errors++; $display("FAIL rst_fill_outputs got %b %h %h exp 00000 0 0",
                               {s_gnt_o, s_rvalid_o, m_req_o, hit_o, miss_o}, m_addr_o, s_rdata_o);
        end
        #2;
        clear_counts();
        do_txn(32'h208, 1'b0, rd, lat, g);
        checks++;
        if (miss_cnt !== 1 || lat !== 17 || rd !== 32'hA5A5_0208) begin
            errors++; $display("FAIL rst_refetch got miss %0d lat %0d data %h exp 1 17 a5a50208", miss_cnt, lat, rd);
        end
        checks++;
        if (addr_log.size() !== 4 || addr_log[0] !== 32'h200) begin
            errors++; $display("FAIL rst_refetch_base got n=%0d exp 4 from 200", addr_log.size());
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_line_replace();
        test_flush_mid_fill();
        test_write();
        test_flush_idle();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_line_buffer.md
Name: spi_flash_line_buffer

Overview:
- Read-only, single-line prefetch buffer on the OBI path to the memory-mapped SPI flash port.
- Sits directly upstream of the OBI SPI flash reader and is fed by the system bus.
- A hit returns the word one cycle after grant.
- A miss fetches the whole aligned line from downstream, one word at a time, then returns the requested word.

Parameters:
- LINE_WORDS, 4, words per line; power of two, >= 2.
- ADDR_WIDTH, 32, OBI address width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  invalidate line (pulse; e.g. on flash reprogram or SPI controller switch)
- s_req_i  in  1  host OBI request
- s_gnt_o  out  1  host OBI grant
- s_addr_i  in  ADDR_WIDTH  host byte address (bits [1:0] ignored)
- s_we_i  in  1  host write enable
- s_rvalid_o  out  1  host response valid
- s_rdata_o  out  32  host response data
- m_req_o  out  1  downstream OBI request (read only; write enable tied 0, byte enable 4'hF)
- m_gnt_i  in  1  downstream grant
- m_addr_o  out  ADDR_WIDTH  downstream word-aligned address
- m_rvalid_i  in  1  downstream response valid
- m_rdata_i  in  32  downstream response data
- hit_o  out  1  one-cycle pulse per accepted read hit
- miss_o  out  1  one-cycle pulse per accepted read miss

Behaviour:
- Reset values (rst_i sampled high at a clock edge):
  - state = IDLE, line valid = 0, flush_pending = 0.
  - All outputs 0, including s_rdata_o and m_addr_o.
- Address split: OFF = log2(LINE_WORDS) + 2.
  - tag = addr[ADDR_WIDTH-1:OFF]; word index = addr[OFF-1:2].
  - Line base = {tag, OFF'b0}.
- Storage: LINE_WORDS x 32 data array, tag register, valid bit.
- State machine: IDLE, REQ, WAIT, RESP.
- IDLE:
  - s_gnt_o = s_req_i, combinational. s_gnt_o is 0 in every other state.
  - Accepted write (s_we_i = 1): data ignored, line untouched. Next cycle s_rvalid_o = 1, s_rdata_o = 0. No hit_o or miss_o.
  - Accepted read, hit (valid and tag match): hit_o = 1 in the grant cycle. Next cycle s_rvalid_o = 1 with the buffered word. Stay in IDLE. Back-to-back hits are granted every cycle.
  - Accepted read, miss: miss_o = 1 in the grant cycle. Latch tag and word index, clear valid, word counter = 0, go to REQ.
- REQ:
  - m_req_o = 1, m_addr_o = line base + 4 * counter.
  - Request and address are held stable until m_gnt_i = 1, then go to WAIT.
- WAIT:
  - m_req_o = 0. On m_rvalid_i, write m_rdata_i into array[counter].
  - If counter == LINE_WORDS-1: go to RESP. Otherwise increment counter and go to REQ.
  - At most one downstream transaction is outstanding at any time.
- RESP:
  - s_rvalid_o = 1 for exactly one cycle, s_rdata_o = array[latched word index].
  - Set valid = !flush_pending, clear flush_pending, go to IDLE.
- Miss latency: fixed 1 grant cycle + LINE_WORDS downstream round trips + 1 response cycle.
- s_rvalid_o never asserts twice for one grant. There is no back-pressure on s_rvalid_o.
- flush_i:
  - In IDLE: valid clears at the next edge. A read hit accepted in the same cycle still returns the pre-flush data.
  - In REQ or WAIT: sets flush_pending. The fill completes and the requested word is returned, but the line stays invalid.
- m_rvalid_i outside WAIT is ignored. m_gnt_i outside REQ is ignored.
- Reset mid-fill: returns to IDLE with valid = 0 and drops m_req_o immediately. The integrator resets the downstream port together with this block, so no stale responses follow.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The counter never carries into the tag.
- Simulation-only assertions:
  - m_addr_o stable while m_req_o && !m_gnt_i.
  - s_gnt_o implies state == IDLE.

Test Plan:
- Cold read 0x0000_0108, downstream model returns data = addr ^ 0xA5A5_0000 with gnt/rvalid after 2 cycles -> m_addr_o sequence 0x100, 0x104, 0x108, 0x10C; s_rdata_o = 0xA5A5_0108; miss_o pulses once.
- Reads 0x100, 0x104, 0x10C back-to-back after the fill -> granted every cycle, rvalid one cycle after each grant, data 0xA5A5_0100 / 0104 / 010C, no m_req_o, hit_o x3.
- Read 0x110 after the line at 0x100 is filled -> miss; m_addr_o 0x110..0x11C; a later read of 0x100 misses again (single line).
- flush_i asserted during the third WAIT of a fill -> the requested word is still returned; an immediate re-read of the same address is a miss.
- Write 0x100 with s_wdata 0xDEAD_BEEF, then read 0x100 -> write returns rvalid with rdata 0; the read hits with the original data.
- rst_i for one cycle while in WAIT -> all outputs 0 the next cycle; a following read of the same line is a miss and refetches from word 0.
